// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the BurstRAM two-port arbiter.
package burst_ram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WR_BURST = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

  localparam int BURST_WORD_BITS     = 64;
  localparam int DEFAULT_BURST_COUNT = 4;
  localparam int BR_MASK_BITS        = BURST_WORD_BITS / 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that did not own the previous burst.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      winner_o = ~last_i;
    end else begin
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM command/data port between two requesters, granting
// whole bursts in round-robin order and holding the grant until the burst ends.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT        = DEFAULT_BURST_COUNT
) (
  input  logic                          clk,
  input  logic                          rst,
  // Handshake: a requester raises mX_req with cmd/addr (and write beat 0)
  // stable and keeps them until the single-cycle mX_gnt pulse; the command is
  // issued to BurstRAM in that same cycle. Write beats advance one cycle after
  // each mX_wr_beat; read beats are qualified by mX_rd_valid.
  input  logic                          m0_req,
  input  logic                          m0_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [BURST_WORD_BITS-1:0]    m0_wr_data,
  output logic                          m0_gnt,
  output logic                          m0_wr_beat,
  output logic                          m0_rd_valid,
  input  logic                          m1_req,
  input  logic                          m1_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [BURST_WORD_BITS-1:0]    m1_wr_data,
  output logic                          m1_gnt,
  output logic                          m1_wr_beat,
  output logic                          m1_rd_valid,
  output logic [BURST_WORD_BITS-1:0]    rd_data,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [BURST_WORD_BITS-1:0]    br_wr_data,
  output logic [BR_MASK_BITS-1:0]       br_data_mask,
  input  logic [BURST_WORD_BITS-1:0]    br_rd_data,
  input  logic                          br_rd_data_valid,
  input  logic                          br_init_calib,
  input  logic                          br_busy,
  output logic [1:0]                    dbg_state
);

  localparam int              CNT_W     = $clog2(BURST_COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

  state_e                      state_q, state_d;
  logic                        owner_q, owner_d;
  logic                        last_q, last_d;
  logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic                        pick_winner, pick_any;
  logic                        own_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] own_addr;
  logic [BURST_WORD_BITS-1:0]  own_wr_data;
  logic [1:0]                  gnt, wr_beat, rd_valid;

  rr_pick2 u_pick (
    .req_i   ({m1_req, m0_req}),
    .last_i  (last_q),
    .winner_o(pick_winner),
    .any_o   (pick_any)
  );

  assign own_cmd     = owner_q ? m1_cmd     : m0_cmd;
  assign own_addr    = owner_q ? m1_addr    : m0_addr;
  assign own_wr_data = owner_q ? m1_wr_data : m0_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    br_cmd_en  = 1'b0;
    br_cmd     = 1'b0;
    br_addr    = '0;
    br_wr_data = '0;
    gnt        = 2'b00;
    wr_beat    = 2'b00;
    rd_valid   = 2'b00;
    case (state_q)
      IDLE: begin
        // BurstRAM readiness is re-checked here before every grant.
        if (br_init_calib && !br_busy && pick_any) begin
          owner_d = pick_winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        br_cmd_en    = 1'b1;
        br_cmd       = own_cmd;
        br_addr      = own_addr;
        br_wr_data   = own_wr_data;
        gnt[owner_q] = 1'b1;
        last_d       = owner_q;
        if (own_cmd) begin
          wr_beat[owner_q] = 1'b1;
          beat_cnt_d       = CNT_W'(1);
          state_d          = WR_BURST;
        end else begin
          beat_cnt_d = '0;
          state_d    = RD_WAIT;
        end
      end
      WR_BURST: begin
        br_wr_data       = own_wr_data;
        wr_beat[owner_q] = 1'b1;
        beat_cnt_d       = beat_cnt_q + CNT_W'(1);
        if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      RD_WAIT: begin
        rd_valid[owner_q] = br_rd_data_valid;
        if (br_rd_data_valid) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt       = gnt[0];
  assign m1_gnt       = gnt[1];
  assign m0_wr_beat   = wr_beat[0];
  assign m1_wr_beat   = wr_beat[1];
  assign m0_rd_valid  = rd_valid[0];
  assign m1_rd_valid  = rd_valid[1];
  assign rd_data      = br_rd_data;
  assign br_data_mask = '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: behavioural BurstRAM model, burst driver tasks,
// per-requester expected read queues and a directed vector table.
module tb_burst_ram_arbiter;
  import burst_ram_pkg::*;

  localparam int  AW  = 4;
  localparam int  BC  = 4;
  localparam int  LAT = 3;
  localparam time PER = 10;

  logic          clk, rst;
  logic          m0_req, m1_req, m0_cmd, m1_cmd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [63:0]   m0_wr_data, m1_wr_data;
  logic          m0_gnt, m1_gnt, m0_wr_beat, m1_wr_beat, m0_rd_valid, m1_rd_valid;
  logic [63:0]   rd_data, br_wr_data, br_rd_data;
  logic          br_cmd, br_cmd_en, br_rd_data_valid, br_init_calib, br_busy;
  logic [AW-1:0] br_addr;
  logic [7:0]    br_data_mask;
  logic [1:0]    dbg_state;

  burst_ram_arbiter #(.RAM_DEPTH_BITWIDTH(AW), .BURST_COUNT(BC)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_wr_beat(m0_wr_beat), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_wr_beat(m1_wr_beat), .m1_rd_valid(m1_rd_valid),
    .rd_data(rd_data), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid), .br_init_calib(br_init_calib),
    .br_busy(br_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #(PER / 2) clk = ~clk;

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] init_word(input int i);
    return {16'hC0DE, 16'(i), 32'hFACE0000 + 32'(i)};
  endfunction

  // ---------------- BurstRAM model ----------------
  logic [63:0] mem [16];
  int          rd_wait, rd_left, wr_left;
  logic [3:0]  rd_ptr, wr_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      rd_wait <= 0; rd_left <= 0; wr_left <= 0;
      rd_ptr <= '0; wr_ptr <= '0;
      br_rd_data_valid <= 1'b0;
      br_rd_data <= '0;
    end else begin
      br_rd_data_valid <= 1'b0;
      if (br_cmd_en && br_cmd) begin
        mem[br_addr] <= br_wr_data;
        wr_ptr  <= br_addr + 4'd1;
        wr_left <= BC - 1;
      end else if (wr_left > 0) begin
        mem[wr_ptr] <= br_wr_data;
        wr_ptr  <= wr_ptr + 4'd1;
        wr_left <= wr_left - 1;
      end
      if (br_cmd_en && !br_cmd) begin
        rd_ptr  <= br_addr;
        rd_wait <= LAT;
        rd_left <= BC;
      end else if (rd_left > 0) begin
        if (rd_wait > 0) begin
          rd_wait <= rd_wait - 1;
        end else begin
          br_rd_data_valid <= 1'b1;
          br_rd_data <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 4'd1;
          rd_left <= rd_left - 1;
        end
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] exp_mem [16];
  int          gnt_log[$];
  int          n_cmd = 0, wb0 = 0, wb1 = 0;
  time         last_rd0_t = 0;
  logic [3:0]  last_cmd_addr = '0;
  logic        last_cmd_wr = 1'b0;

  typedef struct {
    int          m;
    logic        wr;
    logic [3:0]  addr;
    logic [63:0] base;
    int          exp_wr_beats;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (br_cmd_en !== (m0_gnt | m1_gnt)) check("cmd_en_vs_gnt", br_cmd_en, m0_gnt | m1_gnt);
        if (br_cmd_en) begin
          n_cmd++;
          last_cmd_addr = br_addr;
          last_cmd_wr   = br_cmd;
          gnt_log.push_back(m1_gnt ? 1 : 0);
          check("gnt_both", m0_gnt & m1_gnt, 1'b0);
        end
        if (m0_rd_valid && m1_rd_valid) check("rd_valid_overlap", {m1_rd_valid, m0_rd_valid}, 2'b01);
        if (m0_rd_valid) begin
          last_rd0_t = $time;
          if (exp_q0.size() == 0) check("m0_rd_unexpected", m0_rd_valid, 1'b0);
          else check("m0_rd_data", rd_data, exp_q0.pop_front());
        end
        if (m1_rd_valid) begin
          if (exp_q1.size() == 0) check("m1_rd_unexpected", m1_rd_valid, 1'b0);
          else check("m1_rd_data", rd_data, exp_q1.pop_front());
        end
        if (m0_wr_beat) wb0++;
        if (m1_wr_beat) wb1++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int m, input logic req, input logic cmd,
                       input logic [3:0] a, input logic [63:0] d);
    if (m == 0) begin
      m0_req = req; m0_cmd = cmd; m0_addr = a; m0_wr_data = d;
    end else begin
      m1_req = req; m1_cmd = cmd; m1_addr = a; m1_wr_data = d;
    end
  endtask

  function automatic logic get_gnt(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic logic get_wr_beat(input int m);
    return (m == 0) ? m0_wr_beat : m1_wr_beat;
  endfunction

  function automatic int qsize(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic run_burst(input int m, input logic wr, input logic [3:0] a,
                           input logic [63:0] base, output time gnt_t);
    int         w;
    logic       got;
    logic [3:0] ix;
    for (int k = 0; k < BC; k++) begin
      ix = a + 4'(k);
      if (wr) exp_mem[ix] = base * 64'(k + 1);
      else if (m == 0) exp_q0.push_back(exp_mem[ix]);
      else exp_q1.push_back(exp_mem[ix]);
    end
    @(posedge clk); #1;
    set_m(m, 1'b1, wr, a, base);
    got = 1'b0; w = 0; gnt_t = 0;
    while (!got && w < 300) begin
      @(negedge clk);
      if (get_gnt(m)) got = 1'b1;
      else w++;
    end
    check("gnt_seen", got, 1'b1);
    gnt_t = $time;
    if (wr) begin
      check("wr_beat_at_gnt", get_wr_beat(m), 1'b1);
      for (int k = 1; k < BC; k++) begin
        @(posedge clk); #1;
        set_m(m, 1'b0, wr, a, base * 64'(k + 1));
        @(negedge clk);
        check("wr_beat_mid", get_wr_beat(m), 1'b1);
      end
    end
    @(posedge clk); #1;
    set_m(m, 1'b0, 1'b0, '0, '0);
    if (wr) begin
      @(negedge clk);
      check("wr_beat_end", get_wr_beat(m), 1'b0);
    end else begin
      w = 0;
      while (qsize(m) != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("rd_done", qsize(m), 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pulses"}, {m1_gnt, m0_gnt, m1_wr_beat, m0_wr_beat,
                             m1_rd_valid, m0_rd_valid, br_cmd_en, br_cmd}, 8'h00);
    check({tag, "_addr"}, br_addr, 4'd0);
    check({tag, "_wr_data"}, br_wr_data, 64'd0);
    check({tag, "_mask"}, br_data_mask, 8'd0);
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_rd_pass"}, rd_data, br_rd_data);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    br_init_calib = 1'b1;
    br_busy = 1'b0;
    exp_q0.delete(); exp_q1.delete(); gnt_log.delete();
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    time  t0, t1;
    int   c0, b0, beats, w;
    logic got, cal_done;

    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    br_init_calib = 1'b1;
    br_busy = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    fork monitor(); join_none

    vecs[0] = '{0, 1'b0, 4'd2,  64'd0, 0};
    vecs[1] = '{1, 1'b1, 4'd4,  64'h1111_1111_1111_1111, 4};
    vecs[2] = '{1, 1'b0, 4'd4,  64'd0, 0};
    vecs[3] = '{0, 1'b1, 4'd10, {$urandom, $urandom}, 4};
    vecs[4] = '{0, 1'b0, 4'd10, 64'd0, 0};
    vecs[5] = '{1, 1'b0, 4'd0,  64'd0, 0};

    repeat (2) @(negedge clk);
    check_idle("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Tie straight after reset: m0 first, m1 on the first IDLE after m0's last beat.
    fork
      run_burst(0, 1'b0, 4'd0, 64'd0, t0);
      run_burst(1, 1'b0, 4'd8, 64'd0, t1);
    join
    check("tie_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("tie_first", gnt_log[0], 0);
      check("tie_second", gnt_log[1], 1);
    end
    check("m1_turnaround", t1 - last_rd0_t, 2 * PER);

    for (int i = 0; i < 6; i++) begin
      c0 = n_cmd;
      b0 = (vecs[i].m == 0) ? wb0 : wb1;
      run_burst(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].base, t0);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_cmds", i), n_cmd - c0, 1);
      check($sformatf("v%0d_addr", i), last_cmd_addr, vecs[i].addr);
      check($sformatf("v%0d_cmd", i), last_cmd_wr, vecs[i].wr);
      check($sformatf("v%0d_wr_beats", i), ((vecs[i].m == 0) ? wb0 : wb1) - b0, vecs[i].exp_wr_beats);
    end

    // Both requesting continuously: grants must alternate.
    apply_reset();
    fork
      begin
        run_burst(0, 1'b0, 4'd0, 64'd0, t0);
        run_burst(0, 1'b0, 4'd0, 64'd0, t0);
      end
      begin
        run_burst(1, 1'b0, 4'd8, 64'd0, t1);
        run_burst(1, 1'b0, 4'd8, 64'd0, t1);
      end
    join
    check("alt_grants", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("alt_%0d", i), gnt_log[i], i % 2);
    end

    // Held request while BurstRAM is uncalibrated, then busy.
    apply_reset();
    br_init_calib = 1'b0;
    c0 = n_cmd;
    cal_done = 1'b0;
    fork
      begin
        run_burst(0, 1'b0, 4'd6, 64'd0, t0);
        cal_done = 1'b1;
      end
    join_none
    repeat (10) @(negedge clk);
    check("no_cmd_uncal", n_cmd - c0, 0);
    @(posedge clk); #1;
    br_init_calib = 1'b1;
    br_busy = 1'b1;
    repeat (10) @(negedge clk);
    check("no_cmd_busy", n_cmd - c0, 0);
    @(posedge clk); #1;
    br_busy = 1'b0;
    w = 0;
    while (!cal_done && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("cal_burst_done", cal_done, 1'b1);
    repeat (2) @(negedge clk);
    check("cal_one_cmd", n_cmd - c0, 1);

    // Reset during a read after two beats, then a clean m1 read.
    apply_reset();
    for (int k = 0; k < BC; k++) exp_q0.push_back(exp_mem[4'd2 + 4'(k)]);
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 4'd2, '0);
    beats = 0; w = 0; got = 1'b0;
    while (beats < 2 && w < 100) begin
      @(negedge clk);
      w++;
      if (m0_rd_valid) beats++;
      if (m0_gnt) got = 1'b1;
      if (got && m0_req) begin
        @(posedge clk); #1;
        m0_req = 1'b0;
      end
    end
    check("rst_beats", beats, 2);
    check("pre_rst_state", dbg_state, RD_WAIT);
    @(posedge clk); #1;
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0);
    exp_q0.delete();
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    @(negedge clk);
    check_idle("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    c0 = n_cmd;
    run_burst(1, 1'b0, 4'd4, 64'd0, t1);
    repeat (2) @(negedge clk);
    check("post_rst_cmds", n_cmd - c0, 1);
    check("post_rst_q0_empty", exp_q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
